// File: rtl/trace_pkg.sv
// Shared types and layout helpers for the commit trace buffer.
// Entry layout (LSB first): pc, instr, rd_we, rd_addr, rd_data, [ts].
// The timestamp field exists only when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    localparam int OVF_W = 16;
    localparam int RD_W  = 5;

    // Bit offsets of each field inside a packed entry.
    function automatic int off_pc(int xlen);
        off_pc = 0 * xlen;
    endfunction

    function automatic int off_instr(int xlen);
        off_instr = xlen;
    endfunction

    function automatic int off_we(int xlen);
        off_we = 2 * xlen;
    endfunction

    function automatic int off_addr(int xlen);
        off_addr = 2 * xlen + 1;
    endfunction

    function automatic int off_data(int xlen);
        off_data = 2 * xlen + 1 + RD_W;
    endfunction

    function automatic int off_ts(int xlen);
        off_ts = 3 * xlen + 1 + RD_W;
    endfunction

    // ts_w is 0 when timestamps are compiled out.
    function automatic int entry_w(int xlen, int ts_w);
        entry_w = 3 * xlen + 1 + RD_W + ts_w;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Capture/drain bundle between a retiring core, the trace buffer
// and a debug host. master = core/host side, slave = buffer side.
// Ports: capture controls, retire fields, head fields with
// valid/ready, occupancy, drop count, frozen flag and (with
// TRACE_TIMESTAMP_EN) the head timestamp out_ts.
interface commit_trace_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W  = 16
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             enable;
    logic             mode;
    logic             halt_on_full;
    logic             clear;
    logic             retire_valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic             rd_we;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_data;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_instr;
    logic             out_rd_we;
    logic [4:0]       out_rd_addr;
    logic [XLEN-1:0]  out_rd_data;
    logic [CNT_W-1:0] count;
    logic [15:0]      overflow_cnt;
    logic             frozen;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  out_ts;
`endif

    modport master (
        output enable, mode, halt_on_full, clear,
        output retire_valid, pc, instr,
        output rd_we, rd_addr, rd_data, out_ready,
        input  out_valid, out_pc, out_instr,
        input  out_rd_we, out_rd_addr, out_rd_data,
`ifdef TRACE_TIMESTAMP_EN
        input  out_ts,
`endif
        input  count, overflow_cnt, frozen
    );

    modport slave (
        input  enable, mode, halt_on_full, clear,
        input  retire_valid, pc, instr,
        input  rd_we, rd_addr, rd_data, out_ready,
        output out_valid, out_pc, out_instr,
        output out_rd_we, out_rd_addr, out_rd_data,
`ifdef TRACE_TIMESTAMP_EN
        output out_ts,
`endif
        output count, overflow_cnt, frozen
    );

endinterface

// File: rtl/trace_fifo.sv
// Generic W x DEPTH first-word-fall-through FIFO with flush.
// Ports: i_clk, i_rst (sync, high), i_flush, i_push/i_wdata,
// i_pop, o_rdata (head, combinational), o_valid, o_count.
// The caller guarantees push is legal (not full unless popping).
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // Storage carries no reset; only pointers and count do.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: filters committed instructions into a
// circular FWFT buffer drained over valid/ready, counts drops and
// optionally freezes on the first drop. Ports: clock, reset
// (sync, high) and the slave side of commit_trace_buffer_if.
// Macro TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W  = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    commit_trace_buffer_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW    = entry_w(XLEN, TS_W);
`else
    localparam int EW    = entry_w(XLEN, 0);
`endif
    localparam int O_PC  = off_pc(XLEN);
    localparam int O_IN  = off_instr(XLEN);
    localparam int O_WE  = off_we(XLEN);
    localparam int O_RA  = off_addr(XLEN);
    localparam int O_RD  = off_data(XLEN);

    state_t           r_state;
    state_t           w_next;
    logic [OVF_W-1:0] r_ovf;
    logic             w_cap;
    logic             w_capst;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_valid;
    logic [CNT_W-1:0] w_count;
    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;

    // x0 is never a real write, so it is filtered in mode 1.
    assign w_cap = bus.retire_valid
                 & (~bus.mode
                    | (bus.rd_we & (bus.rd_addr != 5'd0)));

    assign w_capst = (r_state == ST_CAPTURE);
    assign w_full  = (w_count == CNT_W'(DEPTH));

    // clear wins over push/pop for the cycle it is asserted.
    assign w_pop  = w_valid & bus.out_ready & ~bus.clear;
    assign w_push = w_capst & w_cap & (~w_full | w_pop)
                  & ~bus.clear;
    assign w_drop = w_capst & w_cap & w_full & ~w_pop
                  & ~bus.clear;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!bus.enable) begin
                    w_next = ST_IDLE;
                end else if (w_drop && bus.halt_on_full) begin
                    w_next = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (bus.clear) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != '1)) begin
            r_ovf <= r_ovf + 1'b1;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    // Free-running; clear leaves the time base alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_wdata = {r_ts, bus.rd_data, bus.rd_addr,
                      bus.rd_we, bus.instr, bus.pc};
    assign bus.out_ts = w_rdata[off_ts(XLEN) +: TS_W];
`else
    assign w_wdata = {bus.rd_data, bus.rd_addr,
                      bus.rd_we, bus.instr, bus.pc};
`endif

    trace_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_flush (bus.clear),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign bus.out_valid    = w_valid;
    assign bus.out_pc       = w_rdata[O_PC +: XLEN];
    assign bus.out_instr    = w_rdata[O_IN +: XLEN];
    assign bus.out_rd_we    = w_rdata[O_WE];
    assign bus.out_rd_addr  = w_rdata[O_RA +: RD_W];
    assign bus.out_rd_data  = w_rdata[O_RD +: XLEN];
    assign bus.count        = w_count;
    assign bus.overflow_cnt = r_ovf;
    assign bus.frozen       = (r_state == ST_FROZEN);

endmodule
